async_fifo_gray: RTL



---
 rtl/async_fifo_gray.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/async_fifo_gray.sv
// Dual-clock Gray-pointer FIFO with occupancy counts, almost flags and sticky error flags.
// Define ASYNC_FIFO_FWFT_EN for first-word fall-through read data; default is registered read, latency 1.
`timescale 1ns/1ps
module async_fifo_gray #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AF_LEVEL    = 6,
  parameter int AE_LEVEL    = 2
) (
  input  logic              w_clk,
  input  logic              r_clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              write,
  input  logic [DATA_W-1:0] data_in,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_count,
  output logic              overflow,
  input  logic              read,
  output logic [DATA_W-1:0] data_out,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   rd_count,
  output logic              underflow
);

  localparam int PW    = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (ADDR_W - 1);
  localparam logic [PW-1:0] AF_LVL    = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_LVL    = PW'(AE_LEVEL);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];

  // ---------------- write domain ----------------
  logic [PW-1:0] wbin_q, wbin_d, wgray_q, wgray_d;
  logic [PW-1:0] rsync_q [SYNC_STAGES];
  logic [PW-1:0] rq;
  logic [PW-1:0] wr_count_q, wr_count_d;
  logic          full_q, full_d, almost_full_q, almost_full_d, overflow_q, overflow_d;
  logic          w_accept;

  assign rq = rsync_q[SYNC_STAGES-1];

  always_comb begin
    w_accept      = en && write && !full_q;
    wbin_d        = w_accept ? (wbin_q + PTR_ONE) : wbin_q;
    wgray_d       = bin2gray(wbin_d);
    wr_count_d    = wbin_d - gray2bin(rq);
    full_d        = (wgray_d == (rq ^ FULL_MASK));
    almost_full_d = (wr_count_d >= AF_LVL);
    overflow_d    = overflow_q | (en & write & full_q);
  end

  // Write-side pointers, read-pointer synchroniser and flags; en low freezes everything.
  always_ff @(posedge w_clk or negedge reset_n) begin
    if (!reset_n) begin
      wbin_q        <= '0;
      wgray_q       <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) rsync_q[i] <= '0;
      wr_count_q    <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else if (en) begin
      wbin_q        <= wbin_d;
      wgray_q       <= wgray_d;
      rsync_q[0]    <= rgray_q;
      for (int i = 1; i < SYNC_STAGES; i++) rsync_q[i] <= rsync_q[i-1];
      wr_count_q    <= wr_count_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge w_clk) begin
    if (w_accept) mem_q[wbin_q[ADDR_W-1:0]] <= data_in;
  end

  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign wr_count    = wr_count_q;
  assign overflow    = overflow_q;

  // ---------------- read domain ----------------
  logic [PW-1:0] rbin_q, rbin_d, rgray_q, rgray_d;
  logic [PW-1:0] wsync_q [SYNC_STAGES];
  logic [PW-1:0] wq;
  logic [PW-1:0] rd_count_q, rd_count_d;
  logic          empty_q, empty_d, almost_empty_q, almost_empty_d, underflow_q, underflow_d;
  logic          r_accept;

  assign wq = wsync_q[SYNC_STAGES-1];

  always_comb begin
    r_accept       = en && read && !empty_q;
    rbin_d         = r_accept ? (rbin_q + PTR_ONE) : rbin_q;
    rgray_d        = bin2gray(rbin_d);
    rd_count_d     = gray2bin(wq) - rbin_d;
    empty_d        = (rgray_d == wq);
    almost_empty_d = (rd_count_d <= AE_LVL);
    underflow_d    = underflow_q | (en & read & empty_q);
  end

  // Read-side pointers, write-pointer synchroniser and flags.
  always_ff @(posedge r_clk or negedge reset_n) begin
    if (!reset_n) begin
      rbin_q         <= '0;
      rgray_q        <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) wsync_q[i] <= '0;
      rd_count_q     <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      underflow_q    <= 1'b0;
    end else if (en) begin
      rbin_q         <= rbin_d;
      rgray_q        <= rgray_d;
      wsync_q[0]     <= wgray_q;
      for (int i = 1; i < SYNC_STAGES; i++) wsync_q[i] <= wsync_q[i-1];
      rd_count_q     <= rd_count_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
      underflow_q    <= underflow_d;
    end
  end

`ifdef ASYNC_FIFO_FWFT_EN
  // Head word is visible straight from storage; meaningless while empty.
  assign data_out = mem_q[rbin_q[ADDR_W-1:0]];
`else
  logic [DATA_W-1:0] dout_q, dout_d;

  always_comb begin
    if (r_accept) dout_d = mem_q[rbin_q[ADDR_W-1:0]];
    else          dout_d = dout_q;
  end

  // Registered read data, updated only on an accepted read.
  always_ff @(posedge r_clk or negedge reset_n) begin
    if (!reset_n) dout_q <= '0;
    else          dout_q <= dout_d;
  end

  assign data_out = dout_q;
`endif

  assign empty        = empty_q;
  assign almost_empty = almost_empty_q;
  assign rd_count     = rd_count_q;
  assign underflow    = underflow_q;

endmodule
